// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame constants,
// and a width helper for the tick and bit counters.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int UART_DBIT      = 8;
  localparam int UART_OVS       = 16;
  localparam int UART_SB_TICK_1 = 16;

  // Counter width for a count range of v, never narrower than 1 bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_tx_ticked_if.sv
// Parallel-side handshake of the ticked UART transmitter: word request in,
// busy and done status back to the producer.
interface uart_tx_ticked_if import uart_pkg::*; #(
  parameter int DBIT = UART_DBIT
) ();
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (output tx_start, din, input tx_busy, tx_done_tick);
  modport slave  (input tx_start, din, output tx_busy, tx_done_tick);
endinterface

// File: rtl/uart_tx_ticked.sv
// UART transmitter paced by an external oversampling tick; frames are start, data LSB first,
// optional parity (define UART_TX_PARITY_EN), stop. tx is a registered output.
module uart_tx_ticked import uart_pkg::*; #(
  parameter int DBIT    = UART_DBIT,
  parameter int OVS     = UART_OVS,
  parameter int SB_TICK = UART_SB_TICK_1
`ifdef UART_TX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_tick,
  uart_tx_ticked_if.slave  txi,
  output logic             tx
);

  localparam int SW = clog2_min1((OVS > SB_TICK) ? OVS : SB_TICK);
  localparam int NW = clog2_min1(DBIT);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (txi.tx_start) begin
        state_d = START;
        s_d     = '0;
        b_d     = txi.din;
`ifdef UART_TX_PARITY_EN
        // Parity is taken from the word as accepted, since the shifter is consumed.
        par_d   = (^txi.din) ^ PARITY_ODD;
`endif
      end
      START: if (s_tick) begin
        if (s_q == S_BIT_LAST) begin
          s_d     = '0;
          n_d     = '0;
          state_d = DATA;
        end else s_d = s_q + SW'(1);
      end
      DATA: if (s_tick) begin
        if (s_q == S_BIT_LAST) begin
          s_d = '0;
          b_d = b_q >> 1;
          if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else n_d = n_q + NW'(1);
        end else s_d = s_q + SW'(1);
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (s_tick) begin
        if (s_q == S_BIT_LAST) begin
          s_d     = '0;
          state_d = STOP;
        end else s_d = s_q + SW'(1);
      end
`endif
      STOP: if (s_tick) begin
        if (s_q == S_STOP_LAST) state_d = IDLE;
        else                    s_d = s_q + SW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_d is decoded from the next state so the line register tracks the state register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    txi.tx_busy      = (state_q != IDLE);
    txi.tx_done_tick = reset && (state_q == STOP) && s_tick && (s_q == S_STOP_LAST);
  end

  assign tx = tx_q;

endmodule
